// File: rtl/misr_signature_checker.sv
// BIST response compactor: folds response words into a right-shift internal-XOR MISR
// and compares the final signature against a golden value. Optional input masking via MISR_X_MASK_EN.
module misr_signature_checker #(
  parameter int n     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [n-1:0]     seed,
  input  logic [n-1:0]     poly,
  input  logic [n-1:0]     golden,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             resp_valid,
  input  logic [n-1:0]     resp_data,
`ifdef MISR_X_MASK_EN
  input  logic [n-1:0]     resp_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [n-1:0]     signature
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [n-2:0]     poly_r;
  logic [n-1:0]     golden_r;
  logic [CNT_W-1:0] num_r;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [n-1:0]     din;
  logic [n-1:0]     misr_next;

  // The top stage has no tap; its poly bit is intentionally dropped.
  logic unused_poly_msb;
  assign unused_poly_msb = poly[n-1];

`ifdef MISR_X_MASK_EN
  assign din = resp_data & ~resp_mask;
`else
  assign din = resp_data;
`endif

  assign count_inc = count + CNT_W'(1);

  // Rotate right; the bit leaving stage 0 feeds stage n-1 and every tapped stage.
  assign misr_next = {signature[0], signature[n-1:1]} ^ din
                   ^ {1'b0, poly_r & {(n-1){signature[0]}}};

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (num_vectors == '0) ? COMPARE : COMPACT;
      COMPACT: if (resp_valid && (count_inc == num_r)) state_next = COMPARE;
      COMPARE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every register here (including the captured session parameters) is
  // cleared by reset; they are flops, not a memory, so the clear costs nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      signature <= '0;
      poly_r    <= '0;
      golden_r  <= '0;
      num_r     <= '0;
      count     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            signature <= seed;
            poly_r    <= poly[n-2:0];
            golden_r  <= golden;
            num_r     <= num_vectors;
            count     <= '0;
            pass      <= 1'b0;
          end
        end
        COMPACT: begin
          if (resp_valid) begin
            signature <= misr_next;
            count     <= count_inc;
          end
        end
        COMPARE: begin
          pass <= (signature == golden_r);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
